// File: rtl/register_pipe_rv_pkg.sv
// Shared helpers for the register pipe library.
//   clog2()     : ceiling log2, usable in parameter defaults
//   cnt_width() : width of an occupancy counter holding 0..depth
//   cnt_op_e    : per-cycle occupancy counter action
package register_pipe_rv_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC,
    CNT_CLR
  } cnt_op_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int cnt_width(input int depth);
    return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
  endfunction

endpackage

// File: rtl/register_pipe_stage.sv
// One pipeline stage: a valid bit plus a payload register.
//   clk, reset : clock, asynchronous active-high reset (clears valid and data)
//   clear      : synchronous clear of the valid bit (data kept)
//   load       : stage takes in_valid/in_data this edge
//   in_valid   : valid bit offered by the previous stage (or the input port)
//   in_data    : payload offered by the previous stage
//   valid/data : stage contents
module register_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // NOTE: data is a handful of flops, not a RAM, so it is reset too; this
  // keeps out_data at 0 during reset instead of exposing stale payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking assignments so every stage samples its
      // neighbour's pre-edge value; blocking here would shoot words through.
      valid <= in_valid;
      // A bubble moving in only clears the valid bit; payload stays put.
      if (in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/register_pipe_rv.sv
// Ready/valid register pipeline with bubble collapsing.
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : synchronous clear of every stage, wins over traffic
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
//   count               : number of valid stages, 0..DEPTH
module register_pipe_rv
  import register_pipe_rv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] ld;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];

  // A stage may load when it is empty or its occupant moves on. Walking from
  // the output back makes the ready path a combinational chain, so a gap
  // anywhere ahead lets the stages behind it close up.
  always_comb begin
    // NOTE: every bit gets a value on every pass, so no latch is inferred.
    ld            = '0;
    ld[DEPTH-1]   = !v[DEPTH-1] || out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      ld[i] = !v[i] || ld[i+1];
    end
  end

  assign in_ready  = !flush && ld[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign src_v[i] = in_valid;
      assign src_d[i] = in_data;
    end else begin : g_body
      assign src_v[i] = v[i-1];
      assign src_d[i] = d[i-1];
    end

    register_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .clear   (flush),
      .load    (ld[i]),
      .in_valid(src_v[i]),
      .in_data (src_d[i]),
      .valid   (v[i]),
      .data    (d[i])
    );
  end

  logic    accept;
  logic    emit;
  cnt_op_e cnt_op;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  always_comb begin
    cnt_op = CNT_HOLD;
    if (flush)                cnt_op = CNT_CLR;
    else if (accept && !emit) cnt_op = CNT_INC;
    else if (emit && !accept) cnt_op = CNT_DEC;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case (cnt_op)
        CNT_INC: count <= count + CNT_W'(1);
        CNT_DEC: count <= count - CNT_W'(1);
        CNT_CLR: count <= '0;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_register_pipe_rv.sv
// Bench for register_pipe_rv: a DEPTH=4 and a DEPTH=1 instance share one
// stimulus. Each has a queue model (words in arrival order, each with the
// stage index it sits in) compared on every falling edge, plus literal
// expectations along the directed scenarios.
module tb_register_pipe_rv;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready4, out_valid4;
  logic [7:0] out_data4;
  logic [2:0] count4;
  logic       in_ready1, out_valid1;
  logic [7:0] out_data1;
  logic [0:0] count1;

  int n_checks = 0;
  int n_fail   = 0;

  register_pipe_rv #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .count(count4)
  );

  register_pipe_rv #(.WIDTH(8), .DEPTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .count(count1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Index 0 models the DEPTH=4 instance, index 1 the DEPTH=1 instance.
  int         mn [2];
  int         mp [2][5];
  logic [7:0] md [2][5];

  function automatic int depth_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // One clock edge: flush empties the pipe; otherwise the oldest word leaves
  // if it sits in the last stage and downstream is ready, every word then
  // moves one stage forward unless blocked by the word ahead, and an
  // accepted word enters stage 0. The pipe refuses input only when full and
  // the output is stalled.
  task automatic step_model(input int k);
    int dep, lim;
    bit rdy, acc, emit;
    dep = depth_of(k);
    if (flush) begin
      mn[k] = 0;
    end else begin
      rdy  = (mn[k] < dep) || out_ready;
      acc  = in_valid && rdy;
      emit = (mn[k] > 0) && (mp[k][0] == dep - 1) && out_ready;
      if (emit) begin
        for (int j = 1; j < mn[k]; j++) begin
          mp[k][j-1] = mp[k][j];
          md[k][j-1] = md[k][j];
        end
        mn[k]--;
      end
      lim = dep - 1;
      for (int j = 0; j < mn[k]; j++) begin
        mp[k][j] = (mp[k][j] + 1 < lim) ? mp[k][j] + 1 : lim;
        lim      = mp[k][j] - 1;
      end
      if (acc) begin
        mp[k][mn[k]] = 0;
        md[k][mn[k]] = in_data;
        mn[k]++;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mn[0] = 0;
      mn[1] = 0;
    end else begin
      step_model(0);
      step_model(1);
    end
  end

  task automatic compare(input int k, input string tag, input logic rdy,
                         input logic ov, input logic [7:0] od, input int cnt);
    int dep;
    bit exp_rdy, exp_ov;
    dep = depth_of(k);
    if (reset) begin
      check({tag, "_rst_in_ready"}, int'(rdy), 1);
      check({tag, "_rst_out_valid"}, int'(ov), 0);
      check({tag, "_rst_out_data"}, int'(od), 0);
      check({tag, "_rst_count"}, cnt, 0);
    end else begin
      exp_rdy = !flush && ((mn[k] < dep) || out_ready);
      exp_ov  = (mn[k] > 0) && (mp[k][0] == dep - 1);
      check({tag, "_in_ready"}, int'(rdy), int'(exp_rdy));
      check({tag, "_out_valid"}, int'(ov), int'(exp_ov));
      check({tag, "_count"}, cnt, mn[k]);
      if (exp_ov) check({tag, "_out_data"}, int'(od), int'(md[k][0]));
    end
  endtask

  always @(negedge clk) begin
    compare(0, "d4", in_ready4, out_valid4, out_data4, int'(count4));
    compare(1, "d1", in_ready1, out_valid1, out_data1, int'(count1));
  end

  // Collects words the DEPTH=1 instance emits during the alternating test.
  bit         collect = 0;
  int         n_got   = 0;
  logic [7:0] got [16];

  always @(negedge clk) begin
    if (collect && !reset && out_valid1 && out_ready && n_got < 16) begin
      got[n_got] = out_data1;
      n_got++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one word on the DEPTH=4 handshake until it is taken; reports the
  // number of edges used.
  task automatic push(input logic [7:0] w, output int cycles);
    bit done;
    done   = 0;
    cycles = 0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      done = in_ready4;
      tick();
      cycles++;
    end
    check("push_accepted", int'(done), 1);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    #1;
    check("reset_out_valid", int'(out_valid4), 0);
    check("reset_count", int'(count4), 0);
    check("reset_in_ready", int'(in_ready4), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Back-to-back stream with downstream always ready.
    push(8'h11, c);
    push(8'h22, c);
    push(8'h33, c);
    check("s1_count_peak", int'(count4), 3);
    check("s1_not_yet_out", int'(out_valid4), 0);
    tick();
    check("s1_out0_valid", int'(out_valid4), 1);
    check("s1_out0", int'(out_data4), 8'h11);
    tick();
    check("s1_out1", int'(out_data4), 8'h22);
    tick();
    check("s1_out2", int'(out_data4), 8'h33);
    tick();
    check("s1_empty_valid", int'(out_valid4), 0);
    check("s1_empty_count", int'(count4), 0);

    // Fill while stalled, then accept and emit on the same edge.
    out_ready = 1'b0;
    push(8'h51, c);
    push(8'h52, c);
    push(8'h53, c);
    push(8'h54, c);
    check("s2_full_count", int'(count4), 4);
    check("s2_full_in_ready", int'(in_ready4), 0);
    check("s2_head", int'(out_data4), 8'h51);
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    tick();
    check("s2_blocked_count", int'(count4), 4);
    check("s2_blocked_data", int'(out_data4), 8'h51);
    out_ready = 1'b1;
    #1;
    check("s2_ready_when_drain", int'(in_ready4), 1);
    tick();
    in_valid = 1'b0;
    check("s2_swap_count", int'(count4), 4);
    check("s2_swap_out", int'(out_data4), 8'h52);
    repeat (3) tick();
    check("s2_last_out", int'(out_data4), 8'h55);
    tick();
    check("s2_drained", int'(count4), 0);

    // Bubble collapse behind a stalled head.
    out_ready = 1'b0;
    push(8'h61, c);
    tick();
    check("s3_in_flight", int'(out_valid4), 0);
    tick();
    tick();
    check("s3_head_arrived", int'(out_valid4), 1);
    check("s3_head_data", int'(out_data4), 8'h61);
    push(8'h62, c);
    push(8'h63, c);
    push(8'h64, c);
    check("s3_full_count", int'(count4), 4);
    check("s3_full_in_ready", int'(in_ready4), 0);
    check("s3_head_kept", int'(out_data4), 8'h61);
    out_ready = 1'b1;
    repeat (5) tick();
    check("s3_drained", int'(count4), 0);

    // Flush with three words held and an offered word.
    out_ready = 1'b0;
    push(8'h71, c);
    push(8'h72, c);
    push(8'h73, c);
    check("s4_count3", int'(count4), 3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h7F;
    #1;
    check("s4_flush_in_ready", int'(in_ready4), 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("s4_flush_count", int'(count4), 0);
    check("s4_flush_valid", int'(out_valid4), 0);
    tick();
    check("s4_no_accept", int'(count4), 0);
    out_ready = 1'b1;
    repeat (2) tick();

    // Reset asserted between edges with two words held.
    out_ready = 1'b0;
    push(8'h81, c);
    push(8'h82, c);
    check("s5_count2", int'(count4), 2);
    #2;
    reset = 1'b1;
    #1;
    check("s5_async_valid", int'(out_valid4), 0);
    check("s5_async_count", int'(count4), 0);
    check("s5_async_data", int'(out_data4), 0);
    check("s5_async_in_ready", int'(in_ready4), 1);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    push(8'h83, c);
    check("s5_first_edge_accept", c, 1);
    repeat (3) tick();
    check("s5_post_reset_out", int'(out_data4), 8'h83);
    repeat (2) tick();

    // DEPTH=1: alternating downstream ready, continuous input.
    n_got   = 0;
    collect = 1'b1;
    begin
      int idx;
      bit acc;
      idx      = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 60 && idx < 8; i++) begin
        in_data = 8'hA0 + 8'(idx);
        #1;
        acc = in_ready1;
        tick();
        if (acc) idx++;
        out_ready = ~out_ready;
      end
      check("s6_all_offered", idx, 8);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    collect = 1'b0;
    check("s6_words_out", n_got, 8);
    for (int i = 0; i < 8 && i < n_got; i++) begin
      check($sformatf("s6_word%0d", i), int'(got[i]), 8'hA0 + i);
    end
    check("s6_d1_empty", int'(count1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_pipe_rv.md
REGISTER_PIPE_RV -- requirements
Module: register_pipe_rv

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of pipeline stages (>=1).
REQ-003 SHALL have parameter CNT_W, default $clog2(DEPTH+1), occupancy count width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous clear of all stage valids.
REQ-007 SHALL have port in_valid  input  1  upstream data valid.
REQ-008 SHALL have port in_ready  output  1  stage 0 can accept this cycle.
REQ-009 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-010 SHALL have port out_valid  output  1  last stage holds valid data.
REQ-011 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-012 SHALL have port out_data  output  WIDTH  last-stage payload.
REQ-013 SHALL have port count  output  CNT_W  number of valid stages, 0..DEPTH.

Function
REQ-014 SHALL hold per stage i (0..DEPTH-1) one valid bit v[i] and one WIDTH data register d[i].
REQ-015 SHALL define advance of last stage as out_valid && out_ready.
REQ-016 SHALL let stage i<DEPTH-1 load from stage i-1 (or input for i=0) when !v[i+1] or stage i+1 loads/advances this cycle (bubble collapsing).
REQ-017 SHALL drive in_ready = !flush && (!v[0] || stage 0 moves forward this cycle); ready path is combinational through the chain.
REQ-018 SHALL accept a word only when in_valid && in_ready; payload unchanged by the pipe.
REQ-019 SHALL, with no stalls, present an accepted word on out_valid/out_data exactly DEPTH cycles after acceptance edge.
REQ-020 SHALL never drop, duplicate or reorder words; d[i] SHALL only change when stage i loads.
REQ-021 SHALL keep out_data stable and out_valid high while out_valid && !out_ready.
REQ-022 SHALL sustain one word per cycle when out_ready is constantly high.
REQ-023 SHALL, when full (count==DEPTH) and out_ready low, drive in_ready low.
REQ-024 SHALL, when full and out_ready high, accept a new word in the same cycle (simultaneous accept and emit).
REQ-025 SHALL update count: +1 on accept only, -1 on emit only, unchanged on both or neither.
REQ-026 SHALL, on flush, clear all v[i] and count to 0 at the next edge; flush overrides accept and emit in that cycle; data registers need not clear.
REQ-027 SHALL, for DEPTH=1, behave as a single-entry pipe with in_ready = !flush && (!v[0] || out_ready).

Reset
REQ-028 SHALL, on reset assertion, immediately clear all v[i], d[i] and count to 0, independent of clk.
REQ-029 SHALL drive out_valid=0, out_data=0, count=0 and in_ready=1 (flush low) while reset is high.
REQ-030 SHALL discard any in-flight words when reset asserts mid-operation; first accept possible on first edge after release.

Structure
REQ-031 SHALL place count-width helper (clog2 function) in the shared package used by the hardware library.
REQ-032 SHALL implement one sub-module register_pipe_stage (valid+data, load enable, async reset) instantiated DEPTH times via generate.
REQ-033 SHALL contain no latches and no internal clock gating.

Verification
REQ-034 SHALL test DEPTH=4, out_ready=1, in words 0x11,0x22,0x33 back-to-back -> out 0x11,0x22,0x33 on cycles 4,5,6 after first accept, count peaks 3.
REQ-035 SHALL test DEPTH=4, out_ready=0, push 5 words -> 4 accepted, in_ready low after 4th, count=4; raise out_ready -> 5th accepted same cycle as first emit, order preserved.
REQ-036 SHALL test bubble collapse: DEPTH=4, one word then out_ready=0 -> word reaches last stage in 4 cycles; next 3 words fill stages 2..0, count=4.
REQ-037 SHALL test flush with count=3 and in_valid=1 -> in_ready=0, word not accepted, next cycle count=0, out_valid=0.
REQ-038 SHALL test reset asserted between edges with count=2 -> out_valid and count 0 immediately, before next clk edge.
REQ-039 SHALL test DEPTH=1, alternating out_ready 1/0 with continuous input 0xA0..0xA7 -> all 8 words out in order, none lost.
